// File: rtl/olivia_pkg.sv
// olivia_pkg: fetch-stage types and default constants shared by the Olivia core.
package olivia_pkg;
    localparam int FETCH_ADDR_W = 64;
    localparam int FETCH_INSTR_W = 32;
    localparam logic [63:0] FETCH_RESET_PC = 64'd0;
    localparam logic [63:0] FETCH_PC_STEP = 64'd4;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FLUSH, HOLD} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: decode-facing output register backed by a one-entry skid.
module fetch_skid_buf
    import olivia_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [ADDR_W-1:0]  in_pc_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic               full_o
);
    logic               out_valid_q, out_valid_d, full_q, full_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d = out_pc_q;
        full_d = full_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d = skid_pc_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            full_d = 1'b0;
        end else if (in_valid_i && out_valid_q && stall_i) begin
            full_d = 1'b1;
            skid_instr_d = in_instr_i;
            skid_pc_d = in_pc_i;
        end else if (in_valid_i) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr_i;
            out_pc_d = in_pc_i;
        end else if (full_q && !stall_i) begin
            out_valid_d = 1'b1;
            out_instr_d = skid_instr_q;
            out_pc_d = skid_pc_q;
            full_d = 1'b0;
        end else if (!stall_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q <= '0;
            full_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q <= out_pc_d;
            full_q <= full_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q <= skid_pc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_pc_o = out_pc_q;
    assign full_o = full_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer
// with branch redirect, stale-response flush and a skid-buffered decode port.
module fetch_ctrl
    import olivia_pkg::*;
#(
    parameter int                ADDR_W = FETCH_ADDR_W,
    parameter int                INSTR_W = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FETCH_PC_STEP)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               stall_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic [ADDR_W-1:0]  pc_out_o
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic              hs, owed, resp_take, skid_full;

    assign hs = (state_q == REQ) && imem_ready_i;
    // A redirect must still swallow a response that was accepted but has not yet returned.
    assign owed = hs || ((state_q == WAIT || state_q == FLUSH) && !imem_rvalid_i);
    assign imem_req_o = state_q == REQ;
    assign imem_addr_o = pc_q;
    assign pc_out_o = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        req_pc_d = req_pc_q;
        resp_take = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: if (hs) begin
                req_pc_d = pc_q;
                pc_d = pc_q + PC_STEP;
                state_d = WAIT;
            end
            WAIT: if (imem_rvalid_i) begin
                resp_take = 1'b1;
                state_d = (if_valid_o && stall_i) ? HOLD : REQ;
            end
            HOLD: if (!stall_i || !skid_full) state_d = REQ;
            FLUSH: if (imem_rvalid_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (branch_taken_i) begin
            pc_d = branch_target_i;
            resp_take = 1'b0;
            state_d = owed ? FLUSH : REQ;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .in_valid_i(resp_take),
        .in_instr_i(imem_rdata_i),
        .in_pc_i(req_pc_q),
        .stall_i(stall_i),
        .flush_i(branch_taken_i),
        .out_valid_o(if_valid_o),
        .out_instr_o(if_instr_o),
        .out_pc_o(if_pc_o),
        .full_o(skid_full)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed per-cycle vector table plus reset corner sequences for fetch_ctrl.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ready, imem_rvalid, branch_taken, stall, if_valid;
    logic [63:0] imem_addr, branch_target, if_pc, pc_out;
    logic [31:0] imem_rdata, if_instr;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .imem_req_o(imem_req),
        .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i(imem_rdata),
        .branch_taken_i(branch_taken),
        .branch_target_i(branch_target),
        .stall_i(stall),
        .if_valid_o(if_valid),
        .if_instr_o(if_instr),
        .if_pc_o(if_pc),
        .pc_out_o(pc_out)
    );

    typedef struct {
        logic        s, b;
        logic [63:0] t;
        logic        r;
        logic        req;
        logic [63:0] pc;
        logic        v;
        logic [63:0] ipc;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic s, b, input logic [63:0] t, input logic r,
                                input logic req, input logic [63:0] pc, input logic v,
                                input logic [63:0] ipc);
        vec_t x;
        x.s = s; x.b = b; x.t = t; x.r = r; x.req = req; x.pc = pc; x.v = v; x.ipc = ipc;
        return x;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // One clock; a memory with 1-cycle latency answers accepted requests with rdata = addr[31:0].
    task automatic step(input logic s, input logic b, input logic [63:0] t, input logic r);
        logic        acc;
        logic [63:0] a;
        stall = s;
        branch_taken = b;
        branch_target = t;
        imem_ready = r;
        acc = imem_req && r;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = acc;
        imem_rdata = a[31:0];
    endtask

    initial begin
        stall = 0; branch_taken = 0; branch_target = 0; imem_ready = 0;
        imem_rvalid = 0; imem_rdata = 0;
        vt[0]  = mk(0, 0, 0,     1, 1, 64'h0,   0, 0);
        vt[1]  = mk(0, 0, 0,     1, 0, 64'h4,   0, 0);
        vt[2]  = mk(0, 0, 0,     1, 1, 64'h4,   1, 64'h0);
        vt[3]  = mk(0, 0, 0,     1, 0, 64'h8,   0, 0);
        vt[4]  = mk(0, 0, 0,     1, 1, 64'h8,   1, 64'h4);
        vt[5]  = mk(1, 0, 0,     1, 0, 64'hC,   1, 64'h4);
        vt[6]  = mk(1, 0, 0,     1, 0, 64'hC,   1, 64'h4);
        vt[7]  = mk(1, 0, 0,     1, 0, 64'hC,   1, 64'h4);
        vt[8]  = mk(0, 0, 0,     1, 1, 64'hC,   1, 64'h8);
        vt[9]  = mk(0, 0, 0,     1, 0, 64'h10,  0, 0);
        vt[10] = mk(0, 0, 0,     1, 1, 64'h10,  1, 64'hC);
        vt[11] = mk(0, 1, 64'h100, 1, 0, 64'h100, 0, 0);
        vt[12] = mk(0, 0, 0,     1, 1, 64'h100, 0, 0);
        vt[13] = mk(0, 0, 0,     1, 0, 64'h104, 0, 0);
        vt[14] = mk(0, 0, 0,     1, 1, 64'h104, 1, 64'h100);
        vt[15] = mk(1, 0, 0,     1, 0, 64'h108, 1, 64'h100);
        vt[16] = mk(1, 1, 64'h200, 1, 1, 64'h200, 0, 0);
        vt[17] = mk(0, 0, 0,     0, 1, 64'h200, 0, 0);
        vt[18] = mk(0, 0, 0,     1, 0, 64'h204, 0, 0);
        vt[19] = mk(0, 0, 0,     1, 1, 64'h204, 1, 64'h200);
        vt[20] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        for (int i = 21; i < 25; i++) vt[i] = mk(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        vt[25] = mk(0, 0, 0,     1, 0, 64'h0,   0, 0);
        vt[26] = mk(0, 0, 0,     1, 1, 64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFC);

        repeat (3) @(posedge clk);
        #1;
        chk("reset req", 64'(imem_req), 0);
        chk("reset pc", pc_out, 0);
        chk("reset ifv", 64'(if_valid), 0);
        chk("reset ifpc", if_pc, 0);
        chk("reset instr", 64'(if_instr), 0);
        rst_n = 1;

        for (int i = 0; i < 27; i++) begin
            step(vt[i].s, vt[i].b, vt[i].t, vt[i].r);
            chk($sformatf("row%0d req", i + 1), 64'(imem_req), 64'(vt[i].req));
            chk($sformatf("row%0d pc", i + 1), pc_out, vt[i].pc);
            if (vt[i].req) chk($sformatf("row%0d addr", i + 1), imem_addr, vt[i].pc);
            chk($sformatf("row%0d ifv", i + 1), 64'(if_valid), 64'(vt[i].v));
            if (vt[i].v) begin
                chk($sformatf("row%0d ifpc", i + 1), if_pc, vt[i].ipc);
                chk($sformatf("row%0d instr", i + 1), 64'(if_instr), 64'(vt[i].ipc[31:0]));
            end
        end

        step(0, 0, 0, 1);
        chk("pre-arst pc", pc_out, 64'h4);
        chk("pre-arst ifv", 64'(if_valid), 0);
        rst_n = 0;
        #1;
        chk("arst req", 64'(imem_req), 0);
        chk("arst pc", pc_out, 0);
        chk("arst ifv", 64'(if_valid), 0);
        chk("arst ifpc", if_pc, 0);
        chk("arst instr", 64'(if_instr), 0);

        @(posedge clk);
        #1;
        rst_n = 1;
        imem_ready = 0;
        imem_rvalid = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("late idle ifv", 64'(if_valid), 0);
        chk("late idle req", 64'(imem_req), 1);
        @(posedge clk);
        #1;
        chk("late req ifv", 64'(if_valid), 0);
        chk("late req addr", imem_addr, 0);
        step(0, 0, 0, 1);
        chk("restart pc", pc_out, 64'h4);
        chk("restart ifv", 64'(if_valid), 0);
        step(0, 0, 0, 1);
        chk("restart if valid", 64'(if_valid), 1);
        chk("restart ifpc", if_pc, 0);
        chk("restart instr", 64'(if_instr), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
